// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - video timing generator and pixel source scheduler for three TMDS encoders
// Two registered stages after the counters: decode/request, then encoder-aligned controls and RGB.
module video_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [23:0] rgb_in,
  output logic        pix_req,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_start,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEGIN  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int          BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [10:0] BAR_DIV = 11'(BAR_W);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        active;
  logic        hs_act;
  logic        vs_act;
  logic        at_origin;

  logic        hs1;
  logic        vs1;
  logic        fs1;
  logic [1:0]  mode1;

  logic [10:0] bar_idx;
  logic [23:0] pix_rgb;

  // Counters park at the origin while disabled so re-enable starts a fresh frame.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  always_comb begin
    active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_act    = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
    vs_act    = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
    at_origin = (h_cnt == 11'd0) && (v_cnt == 10'd0);
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      pix_req <= 1'b0;
      x       <= '0;
      y       <= '0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      fs1     <= 1'b0;
      mode1   <= 2'b00;
    end else if (!en) begin
      pix_req <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      fs1     <= 1'b0;
      mode1   <= mode;
    end else begin
      pix_req <= active;
      hs1     <= hs_act;
      vs1     <= vs_act;
      fs1     <= active && at_origin;
      mode1   <= mode;
      if (active) begin
        x <= h_cnt;
        y <= v_cnt;
      end
    end
  end

  // Pixel source mux; x/y here are the coordinates of the pixel being requested.
  always_comb begin
    pix_rgb = 24'h000000;
    bar_idx = x / BAR_DIV;
    case (mode1)
      2'b00: pix_rgb = rgb_in;
      2'b01: begin
        case (bar_idx)
          11'd0:   pix_rgb = 24'hFFFFFF;
          11'd1:   pix_rgb = 24'hFFFF00;
          11'd2:   pix_rgb = 24'h00FFFF;
          11'd3:   pix_rgb = 24'h00FF00;
          11'd4:   pix_rgb = 24'hFF00FF;
          11'd5:   pix_rgb = 24'hFF0000;
          11'd6:   pix_rgb = 24'h0000FF;
          default: pix_rgb = 24'h000000;
        endcase
      end
      2'b10: begin
        if ((x[4:0] == 5'd0) || (y[4:0] == 5'd0)) begin
          pix_rgb = 24'hFFFFFF;
        end
      end
      default: pix_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      de_o        <= 1'b0;
      hsync_o     <= ~HS_POL;
      vsync_o     <= ~VS_POL;
      frame_start <= 1'b0;
      r_o         <= 8'h00;
      g_o         <= 8'h00;
      b_o         <= 8'h00;
    end else if (!en) begin
      de_o        <= 1'b0;
      hsync_o     <= ~HS_POL;
      vsync_o     <= ~VS_POL;
      frame_start <= 1'b0;
      r_o         <= 8'h00;
      g_o         <= 8'h00;
      b_o         <= 8'h00;
    end else begin
      de_o        <= pix_req;
      hsync_o     <= hs1 ? HS_POL : ~HS_POL;
      vsync_o     <= vs1 ? VS_POL : ~VS_POL;
      frame_start <= fs1;
      if (pix_req) begin
        {r_o, g_o, b_o} <= pix_rgb;
      end else begin
        {r_o, g_o, b_o} <= 24'h000000;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - self-checking bench for video_timing_ctrl on a reduced raster
module tb_video_timing_ctrl;

  localparam int   H_ACTIVE = 64;
  localparam int   H_FP     = 4;
  localparam int   H_SYNC   = 8;
  localparam int   H_BP     = 4;
  localparam int   V_ACTIVE = 16;
  localparam int   V_FP     = 2;
  localparam int   V_SYNC   = 2;
  localparam int   V_BP     = 3;
  localparam logic HS_POL   = 1'b0;
  localparam logic VS_POL   = 1'b0;
  localparam int   HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   FRAME    = HT * VT;

  logic        clk = 1'b0;
  logic        rst_p;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] rgb_in;
  logic        pix_req;
  logic [10:0] x;
  logic [9:0]  y;
  logic        de_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        frame_start;
  logic [7:0]  r_o;
  logic [7:0]  g_o;
  logic [7:0]  b_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  video_timing_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst_p(rst_p), .en(en), .mode(mode), .rgb_in(rgb_in),
    .pix_req(pix_req), .x(x), .y(y), .de_o(de_o), .hsync_o(hsync_o),
    .vsync_o(vsync_o), .frame_start(frame_start), .r_o(r_o), .g_o(g_o), .b_o(b_o)
  );

  // Reference model: raster position per clock plus a record of each cycle's inputs.
  typedef struct {
    bit          en;
    int          h;
    int          v;
    logic [1:0]  mode;
    logic [23:0] rgb;
  } rec_t;

  int          mh, mv;
  rec_t        r1, r2;
  bit          live2;
  bit          exp_req, exp_de, exp_hs_act, exp_vs_act, exp_fs;
  int          exp_x, exp_y, exp_px, exp_py;
  logic [23:0] exp_rgb;

  function automatic bit in_active(input int h, input int v);
    return (h < H_ACTIVE) && (v < V_ACTIVE);
  endfunction

  function automatic logic [23:0] pattern(input logic [1:0] m, input int h, input int v,
                                          input logic [23:0] ext);
    case (m)
      2'b00: return ext;
      2'b01: begin
        case ((h * 8) / H_ACTIVE)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'b10: return (((h % 32) == 0) || ((v % 32) == 0)) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  always @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      mh = 0; mv = 0;
      r2 = '{1'b0, 0, 0, 2'b00, 24'h0};
      exp_req = 0; exp_de = 0; exp_hs_act = 0; exp_vs_act = 0; exp_fs = 0;
      exp_x = 0; exp_y = 0; exp_px = 0; exp_py = 0; exp_rgb = 24'h0;
    end else begin
      r1 = '{en, mh, mv, mode, rgb_in};
      exp_req = r1.en && in_active(r1.h, r1.v);
      if (exp_req) begin
        exp_x = r1.h;
        exp_y = r1.v;
      end
      live2      = r1.en && r2.en;
      exp_de     = live2 && in_active(r2.h, r2.v);
      exp_hs_act = live2 && (r2.h >= H_ACTIVE + H_FP) && (r2.h < H_ACTIVE + H_FP + H_SYNC);
      exp_vs_act = live2 && (r2.v >= V_ACTIVE + V_FP) && (r2.v < V_ACTIVE + V_FP + V_SYNC);
      exp_fs     = live2 && (r2.h == 0) && (r2.v == 0);
      exp_px     = r2.h;
      exp_py     = r2.v;
      exp_rgb    = exp_de ? pattern(r2.mode, r2.h, r2.v, r1.rgb) : 24'h000000;
      if (!r1.en) begin
        mh = 0; mv = 0;
      end else begin
        mh = (mh + 1) % HT;
        if (mh == 0) mv = (mv + 1) % VT;
      end
      r2 = r1;
    end
  end

  task automatic test_reset();
    rst_p = 1'b1; en = 1'b0; mode = 2'b00; rgb_in = 24'h0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({pix_req, de_o, frame_start, hsync_o, vsync_o} !== {3'b000, ~HS_POL, ~VS_POL}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected %b", {pix_req, de_o, frame_start, hsync_o, vsync_o},
               {3'b000, ~HS_POL, ~VS_POL});
    end
    n_tests++;
    if ({x, y, r_o, g_o, b_o} !== 45'h0) begin
      n_fail++;
      $display("FAIL reset_data: got x=%0d y=%0d rgb=%h expected all zero", x, y, {r_o, g_o, b_o});
    end
    rst_p = 1'b0; en = 1'b1; mode = 2'b01;
    @(negedge clk);
    n_tests++;
    if ({pix_req, de_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL start_req: got req/de=%b expected 10", {pix_req, de_o});
    end
    @(negedge clk);
    n_tests++;
    if ({de_o, frame_start} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_de: got de/fs=%b expected 11", {de_o, frame_start});
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (de_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midline_de: got %b expected 1", de_o);
    end
    rst_p = 1'b1;
    #1;
    n_tests++;
    if ({pix_req, de_o, frame_start, hsync_o, vsync_o, x, y, r_o, g_o, b_o} !==
        {3'b000, ~HS_POL, ~VS_POL, 45'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b de=%b fs=%b hs=%b vs=%b x=%0d y=%0d rgb=%h expected reset values",
               pix_req, de_o, frame_start, hsync_o, vsync_o, x, y, {r_o, g_o, b_o});
    end
    @(negedge clk);
    rst_p = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({de_o, frame_start} !== 2'b11) begin
      n_fail++;
      $display("FAIL restart_fs: got de/fs=%b expected 11", {de_o, frame_start});
    end
  endtask

  task automatic test_line_timing();
    int de_end, de_cnt, hs_start, hs_cnt;
    bit got;
    en = 1'b1; mode = 2'b01;
    got = 0;
    for (int i = 0; i < 2 * FRAME + 10 && !got; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) got = 1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL line_wait: got no frame_start expected one within %0d cycles", 2 * FRAME);
    end else begin
      de_end = -1; de_cnt = 0; hs_start = -1; hs_cnt = 0;
      for (int k = 0; k < HT; k++) begin
        if (k > 0) @(negedge clk);
        if (de_o === 1'b1) de_cnt++;
        else if (de_end < 0) de_end = k;
        if (hsync_o === HS_POL) begin
          if (hs_start < 0) hs_start = k;
          hs_cnt++;
        end
      end
      @(negedge clk);
      n_tests++;
      if (de_end != H_ACTIVE || de_cnt != H_ACTIVE) begin
        n_fail++;
        $display("FAIL line_de: got run=%0d count=%0d expected %0d", de_end, de_cnt, H_ACTIVE);
      end
      n_tests++;
      if (hs_start != H_ACTIVE + H_FP) begin
        n_fail++;
        $display("FAIL line_hs_start: got %0d expected %0d", hs_start, H_ACTIVE + H_FP);
      end
      n_tests++;
      if (hs_cnt != H_SYNC) begin
        n_fail++;
        $display("FAIL line_hs_width: got %0d expected %0d", hs_cnt, H_SYNC);
      end
      n_tests++;
      if (de_o !== 1'b1) begin
        n_fail++;
        $display("FAIL line_period: got de=%b at cycle %0d expected 1", de_o, HT);
      end
    end
  endtask

  task automatic test_frame_timing();
    int rises, vs_cnt, vs_start, fs_cnt;
    bit got, prev;
    en = 1'b1; mode = 2'b10;
    got = 0;
    for (int i = 0; i < 2 * FRAME + 10 && !got; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) got = 1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL frame_wait: got no frame_start expected one within %0d cycles", 2 * FRAME);
    end else begin
      rises = 0; vs_cnt = 0; vs_start = -1; fs_cnt = 0; prev = 0;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        if (de_o === 1'b1 && !prev) rises++;
        prev = (de_o === 1'b1);
        if (frame_start === 1'b1) fs_cnt++;
        if (vsync_o === VS_POL) begin
          if (vs_start < 0) vs_start = k;
          vs_cnt++;
        end
      end
      @(negedge clk);
      n_tests++;
      if (rises != V_ACTIVE) begin
        n_fail++;
        $display("FAIL frame_lines: got %0d expected %0d", rises, V_ACTIVE);
      end
      n_tests++;
      if (vs_cnt != V_SYNC * HT || vs_start != (V_ACTIVE + V_FP) * HT) begin
        n_fail++;
        $display("FAIL frame_vsync: got start=%0d len=%0d expected start=%0d len=%0d",
                 vs_start, vs_cnt, (V_ACTIVE + V_FP) * HT, V_SYNC * HT);
      end
      n_tests++;
      if (fs_cnt != 1 || frame_start !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_period: got fs_count=%0d next_fs=%b expected 1 and 1", fs_cnt, frame_start);
      end
    end
  endtask

  task automatic test_bars();
    bit got;
    en = 1'b1; mode = 2'b01;
    got = 0;
    for (int i = 0; i < 2 * FRAME + 10 && !got; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) got = 1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL bars_wait: got no frame_start expected one within %0d cycles", 2 * FRAME);
    end else begin
      for (int k = 0; k < HT; k++) begin
        if (k > 0) @(negedge clk);
        if (exp_px == 0 || exp_px == H_ACTIVE / 8 || exp_px == (H_ACTIVE * 5) / 8 ||
            exp_px == H_ACTIVE - 1 || exp_px == H_ACTIVE + 2) begin
          logic [23:0] want;
          case (exp_px)
            0:               want = 24'hFFFFFF;
            H_ACTIVE / 8:    want = 24'hFFFF00;
            (H_ACTIVE*5)/8:  want = 24'hFF0000;
            default:         want = 24'h000000;
          endcase
          n_tests++;
          if ({r_o, g_o, b_o} !== want) begin
            n_fail++;
            $display("FAIL bars_px%0d: got %h expected %h", exp_px, {r_o, g_o, b_o}, want);
          end
        end
      end
    end
  endtask

  task automatic test_external();
    bit hit;
    en = 1'b1; mode = 2'b00;
    hit = 0;
    for (int i = 0; i < 2 * FRAME + 10 && !hit; i++) begin
      @(negedge clk);
      if (exp_req && exp_x == 5 && exp_y == 7) begin
        rgb_in = 24'h123456;
        hit = 1;
      end else begin
        rgb_in = 24'($urandom);
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL ext_wait: got no request for (5,7) expected one within %0d cycles", 2 * FRAME);
    end else begin
      n_tests++;
      if ({pix_req, x, y} !== {1'b1, 11'd5, 10'd7}) begin
        n_fail++;
        $display("FAIL ext_req: got req=%b x=%0d y=%0d expected 1 5 7", pix_req, x, y);
      end
      @(negedge clk);
      rgb_in = 24'($urandom);
      n_tests++;
      if ({de_o, r_o, g_o, b_o} !== {1'b1, 24'h123456}) begin
        n_fail++;
        $display("FAIL ext_pixel: got de=%b rgb=%h expected de=1 rgb=123456", de_o, {r_o, g_o, b_o});
      end
    end
  endtask

  task automatic test_enable_toggle();
    bit got;
    en = 1'b1; mode = 2'b01;
    got = 0;
    for (int i = 0; i < 2 * FRAME + 10 && !got; i++) begin
      @(negedge clk);
      if (mh == 30 && mv == 10) got = 1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL toggle_wait: got no position (30,10) expected one within %0d cycles", 2 * FRAME);
    end else begin
      en = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({de_o, pix_req, hsync_o, vsync_o, r_o, g_o, b_o} !== {2'b00, ~HS_POL, ~VS_POL, 24'h0}) begin
        n_fail++;
        $display("FAIL disable_idle: got de=%b req=%b hs=%b vs=%b rgb=%h expected idle",
                 de_o, pix_req, hsync_o, vsync_o, {r_o, g_o, b_o});
      end
      repeat (5) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({pix_req, x, y, frame_start} !== {1'b1, 11'd0, 10'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reenable_req: got req=%b x=%0d y=%0d fs=%b expected 1 0 0 0", pix_req, x, y, frame_start);
      end
      @(negedge clk);
      n_tests++;
      if ({de_o, frame_start} !== 2'b11) begin
        n_fail++;
        $display("FAIL reenable_fs: got de/fs=%b expected 11", {de_o, frame_start});
      end
    end
  endtask

  task automatic test_random();
    int off_len;
    off_len = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      n_tests++;
      if ({pix_req, de_o, frame_start} !== {exp_req, exp_de, exp_fs}) begin
        n_fail++;
        $display("FAIL rnd_ctrl cycle %0d: got req/de/fs=%b expected %b", i, {pix_req, de_o, frame_start},
                 {exp_req, exp_de, exp_fs});
      end
      n_tests++;
      if ({hsync_o, vsync_o} !== {(exp_hs_act ? HS_POL : ~HS_POL), (exp_vs_act ? VS_POL : ~VS_POL)}) begin
        n_fail++;
        $display("FAIL rnd_sync cycle %0d: got hs/vs=%b expected active %b", i, {hsync_o, vsync_o},
                 {exp_hs_act, exp_vs_act});
      end
      n_tests++;
      if ({x, y} !== {11'(exp_x), 10'(exp_y)}) begin
        n_fail++;
        $display("FAIL rnd_xy cycle %0d: got x=%0d y=%0d expected x=%0d y=%0d", i, x, y, exp_x, exp_y);
      end
      n_tests++;
      if ({r_o, g_o, b_o} !== exp_rgb) begin
        n_fail++;
        $display("FAIL rnd_rgb cycle %0d: got %h expected %h (px %0d,%0d)", i, {r_o, g_o, b_o}, exp_rgb,
                 exp_px, exp_py);
      end
      rgb_in = 24'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if (off_len > 0) begin
        off_len--;
        en = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        off_len = $urandom_range(0, 6);
        en = 1'b0;
      end else begin
        en = 1'b1;
      end
    end
  endtask

  initial begin
    rst_p = 1'b1; en = 1'b0; mode = 2'b00; rgb_in = 24'h0;
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_bars();
    test_external();
    test_enable_toggle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
